fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I core.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers the returned instructions and presents one registered instruction per cycle to decode, which feeds the immediate generator and control decoder.
- Handles the hazard-unit stall and the EX-stage branch/jump redirect, including discarding wrong-path responses that are still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- BUF_DEPTH, 2, instruction buffer entries; also caps requests in flight plus entries buffered (minimum 2).
- NOP_INST, 32'h0000_0013, encoding (addi x0,x0,0) driven on id_inst during a bubble.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address (current PC)
- imem_rsp_valid  in  1  response valid; responses are in order, never back-pressured, at least 1 cycle after acceptance
- imem_rsp_data  in  32  fetched instruction word
- redirect_valid  in  1  EX-stage taken branch/JAL/JALR
- redirect_pc  in  32  redirect target
- id_stall  in  1  hazard unit holds the IF/ID register
- id_valid  out  1  IF/ID holds a real instruction
- id_inst  out  32  instruction to decode
- id_pc  out  32  PC of id_inst
- id_pc4  out  32  id_pc + 4, used for JAL/JALR link

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC; outstanding=0; drop_cnt=0; buffer empty.
  - id_valid=0, id_inst=NOP_INST, id_pc=0, id_pc4=0.
  - imem_req_valid=0 while reset is asserted.
  - Reset asserted mid-operation discards everything in flight.
  - The first request is issued in the first cycle after deassertion.
- Request issue:
  - imem_req_valid = !redirect_valid && (outstanding + buf_count < BUF_DEPTH).
  - imem_req_addr = pc.
  - On handshake: pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0) and outstanding++.
  - The counters are not bypassed: a pop in the same cycle does not free a credit until the next cycle.
- Response:
  - outstanding-- on every imem_rsp_valid.
  - If drop_cnt > 0, the response is discarded and drop_cnt-- (wrong path).
  - Otherwise the {pc, inst} pair is delivered: bypassed into IF/ID if the buffer is empty and the IF/ID register is loading this cycle, else pushed into the buffer.
  - The credit rule guarantees the buffer never overflows. A push when full is an assertion failure.
  - The PC of each response is tracked alongside the buffer entry; the response PC is the issue PC, kept in a PC shadow per credit.
- IF/ID register update:
  - When !id_stall: load the buffer head (pop), else the bypassed response, else a bubble (id_valid=0, id_inst=NOP_INST; id_pc and id_pc4 hold).
  - When id_stall: hold all id_* outputs; no pop occurs.
- Redirect (priority over stall and over every other event in the cycle):
  - pc <= {redirect_pc[31:2], 2'b00}; low bits are forced to zero.
  - No request is issued this cycle.
  - The buffer is cleared and IF/ID is flushed to a bubble at the next edge.
  - drop_cnt <= outstanding - imem_rsp_valid; a response arriving in the redirect cycle is itself discarded.
  - A second redirect while drop_cnt > 0 recomputes drop_cnt from outstanding, so no wrong-path instruction is ever delivered.
- Latency and throughput:
  - With 1-cycle memory and no stall: request in cycle N, response in N+1, id_valid=1 after the N+1 edge.
  - Sustains 1 instruction per cycle at 1-cycle memory latency.
  - Redirect penalty is 2 bubbles.
- imem_req_ready=0: pc holds, imem_req_valid stays high, and the address holds until accepted unless a redirect occurs.

Decomposition:
- riscv_pkg additions:
  - NOP_INST constant.
  - RESET_PC default.
  - if_id_t struct {valid, pc, pc4, inst} shared with the ID stage.
- One sub-module, fetch_buf: a synchronous FIFO of {pc, inst} with count, clear, push, pop, and same-cycle push+pop.

Test Plan:
- Reset then free-run, 1-cycle memory, ready=1 -> requests at 0x0, 0x4, 0x8; id_pc 0x0, 0x4, 0x8 on consecutive cycles, id_pc4 0x4, 0x8, 0xC; no gaps.
- id_stall high for 3 cycles with id_pc=0x8 -> id_* holds 0x8; at most BUF_DEPTH=2 requests in flight plus buffered; after release, 0xC and 0x10 follow with no loss or duplication.
- redirect_valid with redirect_pc=0x100 while 2 requests are outstanding -> both responses dropped; next id_valid shows id_pc=0x100, id_pc4=0x104; id_inst=0x00000013 during the 2 bubbles.
- Redirect in the same cycle as imem_rsp_valid and id_stall=1 -> that response is discarded, IF/ID flushed to a bubble, next fetch address 0x100.
- imem_req_ready=0 for 4 cycles at pc=0x20 -> address holds at 0x20, id_valid=0 once the buffer drains; resumes at 0x20 on ready.
- rst_n pulsed low while 2 requests are outstanding and the buffer is full -> all outputs at reset values immediately; first request after release is RESET_PC; stale responses from before reset are not delivered.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions used by the fetch stage and the ID stage.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    // IF/ID pipeline register contents handed to decode
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
    } if_id_t;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO with occupancy count, clear, and same-cycle push+pop.
module fetch_buf #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Wrap a pointer at DEPTH so non-power-of-two depths stay in range
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head = mem[rd_ptr];

    // Storage array; no reset needed since count qualifies every read
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; clear wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && !pop && count == CNT_W'(DEPTH)));
            assert (!(pop && count == '0));
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with credit-limited requests, response buffer and IF/ID register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter int unsigned BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INST  = riscv_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned ENT_W = 64;

    logic [31:0]      pc;
    logic [31:0]      pc_next;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] drop_next;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W-1:0] shadow_count;
    if_id_t           if_id;
    if_id_t           if_id_next;

    logic             credit_ok;
    logic             handshake;
    logic             rsp_live;
    logic             id_load;
    logic             buf_empty;
    logic             bypass;
    logic             buf_push;
    logic             buf_pop;
    logic [ENT_W-1:0] buf_head;
    logic [31:0]      rsp_pc;

    // Request channel and per-cycle event decode
    assign credit_ok      = (SUM_W'(outstanding) + SUM_W'(buf_count)) < SUM_W'(BUF_DEPTH);
    assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc;
    assign handshake      = imem_req_valid && imem_req_ready;
    assign rsp_live       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign id_load        = !id_stall && !redirect_valid;
    assign buf_empty      = (buf_count == '0);
    assign bypass         = rsp_live && buf_empty && id_load;
    assign buf_push       = rsp_live && !bypass;
    assign buf_pop        = id_load && !buf_empty;

    // Issue PC of each in-flight request, consumed as responses return
    fetch_buf #(
        .WIDTH (32),
        .DEPTH (BUF_DEPTH)
    ) u_pc_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (1'b0),
        .push      (handshake),
        .push_data (pc),
        .pop       (imem_rsp_valid),
        .head      (rsp_pc),
        .count     (shadow_count)
    );

    // Returned {pc, inst} pairs waiting for the IF/ID register
    fetch_buf #(
        .WIDTH (ENT_W),
        .DEPTH (BUF_DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_valid),
        .push      (buf_push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (buf_pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    // Next PC, credit/drop counters and IF/ID contents; redirect overrides everything
    always_comb begin
        pc_next          = pc;
        outstanding_next = outstanding + CNT_W'(handshake) - CNT_W'(imem_rsp_valid);
        drop_next        = drop_cnt;
        if_id_next       = if_id;

        if (redirect_valid) begin
            pc_next          = {redirect_pc[31:2], 2'b00};
            drop_next        = outstanding - CNT_W'(imem_rsp_valid);
            if_id_next.valid = 1'b0;
            if_id_next.inst  = NOP_INST;
        end else begin
            if (handshake) begin
                pc_next = pc + 32'd4;
            end
            if (imem_rsp_valid && drop_cnt != '0) begin
                drop_next = drop_cnt - CNT_W'(1);
            end
            if (id_load) begin
                if (buf_pop) begin
                    if_id_next = '{valid: 1'b1,
                                   pc:    buf_head[63:32],
                                   pc4:   buf_head[63:32] + 32'd4,
                                   inst:  buf_head[31:0]};
                end else if (bypass) begin
                    if_id_next = '{valid: 1'b1,
                                   pc:    rsp_pc,
                                   pc4:   rsp_pc + 32'd4,
                                   inst:  imem_rsp_data};
                end else begin
                    if_id_next.valid = 1'b0;
                    if_id_next.inst  = NOP_INST;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            if_id       <= '{valid: 1'b0, pc: 32'd0, pc4: 32'd0, inst: NOP_INST};
        end else begin
            assert (shadow_count == outstanding);
            pc          <= pc_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_next;
            if_id       <= if_id_next;
        end
    end

    assign id_valid = if_id.valid;
    assign id_inst  = if_id.inst;
    assign id_pc    = if_id.pc;
    assign id_pc4   = if_id.pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a variable-latency in-order memory model.
`timescale 1ns/1ps
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (DEPTH),
        .NOP_INST  (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mem_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          arrived;
    } exp_t;

    mem_t        mq[$];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    int          n_deliv = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_pc4 = 32'd0;
    logic [31:0] m_inst = NOP;
    logic [31:0] m_fpc = 32'd0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0093;
    endfunction

    function automatic int arrived_cnt();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].arrived) n++;
        return n;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory and scoreboard model, advanced at each active edge or reset
    initial forever begin
        mem_t h;
        exp_t e;
        bit   marked;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            epoch++;
            m_valid = 1'b0;
            m_inst  = NOP;
            m_pc    = 32'd0;
            m_pc4   = 32'd0;
            m_fpc   = 32'd0;
        end else begin
            cyc++;
            if (imem_rsp_valid && mq.size() > 0) begin
                h = mq.pop_front();
                if (h.epoch == epoch) begin
                    marked = 1'b0;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (!marked && !exp_q[i].arrived) begin
                            exp_q[i].arrived = 1'b1;
                            marked = 1'b1;
                        end
                    end
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                epoch++;
                m_valid = 1'b0;
                m_inst  = NOP;
                m_fpc   = {redirect_pc[31:2], 2'b00};
            end else begin
                if (!id_stall) begin
                    if (exp_q.size() > 0 && exp_q[0].arrived) begin
                        e = exp_q.pop_front();
                        m_valid = 1'b1;
                        m_pc    = e.pc;
                        m_pc4   = e.pc + 32'd4;
                        m_inst  = e.inst;
                        n_deliv++;
                    end else begin
                        m_valid = 1'b0;
                        m_inst  = NOP;
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    h.addr  = imem_req_addr;
                    h.due   = cyc + lat - 1;
                    h.epoch = epoch;
                    mq.push_back(h);
                    e.pc      = m_fpc;
                    e.inst    = inst_of(m_fpc);
                    e.arrived = 1'b0;
                    exp_q.push_back(e);
                    m_fpc = m_fpc + 32'd4;
                end
            end
        end
    end

    // Compare DUT against the model mid-cycle, then present the next response
    initial forever begin
        logic exp_rv;
        @(negedge clk);
        check_eq("id_valid", 32'(id_valid), 32'(m_valid));
        check_eq("id_inst", id_inst, m_inst);
        check_eq("id_pc", id_pc, m_pc);
        check_eq("id_pc4", id_pc4, m_pc4);
        exp_rv = rst_n && !redirect_valid && ((mq.size() + arrived_cnt()) < int'(DEPTH));
        check_eq("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check_eq("req_addr", imem_req_addr, m_fpc);
        if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step(1);
        redirect_valid = 1'b0;
    endtask

    initial begin
        step(3);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_id_inst", id_inst, NOP);
        rst_n = 1'b1;

        // Free-run at 1-cycle latency
        step(8);

        // Hold IF/ID for three cycles
        id_stall = 1'b1;
        step(3);
        id_stall = 1'b0;
        step(6);

        // Redirect with two slow responses in flight
        lat = 3;
        step(6);
        redirect_to(32'h0000_0100);
        step(10);

        // Redirect coinciding with a response and a stall
        lat = 1;
        step(5);
        id_stall = 1'b1;
        redirect_to(32'h0000_0100);
        id_stall = 1'b0;
        step(6);

        // Back-pressure at a misaligned redirect target
        imem_req_ready = 1'b0;
        redirect_to(32'h0000_0023);
        step(4);
        imem_req_ready = 1'b1;
        step(6);

        // PC wraparound
        redirect_to(32'hFFFF_FFF4);
        step(6);

        // Back-to-back redirects while wrong-path responses are pending
        lat = 3;
        step(4);
        redirect_to(32'h0000_0200);
        redirect_to(32'h0000_0300);
        step(10);

        // Asynchronous reset with buffer and requests busy
        id_stall = 1'b1;
        step(5);
        rst_n = 1'b0;
        #1;
        check_eq("async_id_valid", 32'(id_valid), 32'd0);
        check_eq("async_id_inst", id_inst, NOP);
        check_eq("async_id_pc", id_pc, 32'd0);
        check_eq("async_id_pc4", id_pc4, 32'd0);
        check_eq("async_req_valid", 32'(imem_req_valid), 32'd0);
        id_stall = 1'b0;
        lat = 1;
        step(2);
        rst_n = 1'b1;
        step(8);

        check_eq("deliveries", 32'(n_deliv > 30), 32'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
